// File: rtl/lcd_pkg.sv
// Shared state types, HD44780 command bytes, init tables and default timing
// for the character-LCD sequencer.
`timescale 1ns/1ps
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_NIB,
        INIT_WAIT,
        IDLE,
        NIB_HI,
        GAP,
        NIB_LO,
        POST_WAIT
    } lcd_state_t;

    typedef enum logic [1:0] {
        STB_IDLE,
        STB_SETUP,
        STB_PULSE,
        STB_HOLD
    } strobe_state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;

    // Cycle counts for a 50 MHz clock
    localparam int DEF_T_PWRON = 750000;
    localparam int DEF_T_INIT1 = 205000;
    localparam int DEF_T_INIT2 = 5000;
    localparam int DEF_T_SHORT = 2000;
    localparam int DEF_T_CLEAR = 82000;
    localparam int DEF_T_NIB   = 50;
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 12;
    localparam int DEF_T_HOLD  = 1;

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_FUNC_SET;
            2'd1:    b = LCD_ENTRY;
            2'd2:    b = LCD_DISP_ON;
            default: b = LCD_CLEAR;
        endcase
        return b;
    endfunction

    // Clear-display and return-home need the long post-command wait
    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Drives one 4-bit LCD bus transfer: RS/DB setup, E high pulse, hold, then a
// one-cycle done pulse during the last hold cycle.
`timescale 1ns/1ps
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_db,
    output logic       done
);

    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_T = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
    localparam int CW    = $clog2(MAX_T + 1);

    strobe_state_t   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      nib_q, nib_d;
    logic            rs_q, rs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STB_IDLE;
            cnt_q   <= '0;
            nib_q   <= 4'h0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            rs_q    <= rs_d;
        end
    end

    // RS/DB are captured at start so they stay fixed through SETUP..HOLD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        rs_d    = rs_q;
        done    = 1'b0;
        case (state_q)
            STB_IDLE: begin
                if (start) begin
                    state_d = STB_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                    nib_d   = nibble;
                    rs_d    = rs;
                end
            end
            STB_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STB_PULSE;
                    cnt_d   = CW'(T_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STB_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = STB_HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STB_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = STB_IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = STB_IDLE;
        endcase
    end

    assign lcd_e  = (state_q == STB_PULSE);
    assign lcd_rs = rs_q;
    assign lcd_db = nib_q;

endmodule

// File: rtl/lcd_sequencer.sv
// 4-bit HD44780 bus sequencer: power-on init then byte writes over valid/ready.
// Define LCD_INIT_EN to build the power-on initialisation sequence in.
`timescale 1ns/1ps
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int T_PWRON = DEF_T_PWRON,
    parameter int T_INIT1 = DEF_T_INIT1,
    parameter int T_INIT2 = DEF_T_INIT2,
    parameter int T_SHORT = DEF_T_SHORT,
    parameter int T_CLEAR = DEF_T_CLEAR,
    parameter int T_NIB   = DEF_T_NIB,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic       sf_e,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    localparam int M0 = (T_PWRON > T_INIT1) ? T_PWRON : T_INIT1;
    localparam int M1 = (M0 > T_INIT2) ? M0 : T_INIT2;
    localparam int M2 = (M1 > T_SHORT) ? M1 : T_SHORT;
    localparam int M3 = (M2 > T_CLEAR) ? M2 : T_CLEAR;
    localparam int MAX_T = (M3 > T_NIB) ? M3 : T_NIB;
    localparam int CW    = $clog2(MAX_T + 1);

`ifdef LCD_INIT_EN
    localparam lcd_state_t    RESET_STATE = PWR_WAIT;
    localparam logic [CW-1:0] RESET_CNT   = CW'(T_PWRON - 1);
`else
    localparam lcd_state_t    RESET_STATE = IDLE;
    localparam logic [CW-1:0] RESET_CNT   = '0;
`endif

    lcd_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          init_done_q, init_done_d;

    logic          stb_start;
    logic [3:0]    stb_nibble;
    logic          stb_rs;
    logic          stb_done;

`ifdef LCD_INIT_EN
    logic [1:0]    idx_q, idx_d;
    logic          in_init_q, in_init_d;
    logic [7:0]    next_byte;

    function automatic logic [CW-1:0] init_wait(input logic [1:0] idx);
        logic [CW-1:0] w;
        case (idx)
            2'd0:    w = CW'(T_INIT1 - 1);
            2'd1:    w = CW'(T_INIT2 - 1);
            default: w = CW'(T_SHORT - 1);
        endcase
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= 2'd0;
            in_init_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            in_init_q <= in_init_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= RESET_CNT;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            init_done_q <= init_done_d;
        end
    end

    // Strobe start is issued on the same edge a wait expires, so no idle cycle
    // is inserted between a finished wait and the next SETUP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        init_done_d = init_done_q;
        stb_start   = 1'b0;
        stb_nibble  = 4'h0;
        stb_rs      = 1'b0;
`ifdef LCD_INIT_EN
        idx_d       = idx_q;
        in_init_d   = in_init_q;
        next_byte   = 8'h00;
`else
        init_done_d = 1'b1;
`endif
        case (state_q)
`ifdef LCD_INIT_EN
            PWR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = INIT_NIB;
                    stb_start  = 1'b1;
                    stb_nibble = init_nibble(2'd0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            INIT_NIB: begin
                if (stb_done) begin
                    state_d = INIT_WAIT;
                    cnt_d   = init_wait(idx_q);
                end
            end
            INIT_WAIT: begin
                if (cnt_q == '0) begin
                    stb_start = 1'b1;
                    if (idx_q == 2'd3) begin
                        next_byte  = init_byte(2'd0);
                        idx_d      = 2'd0;
                        in_init_d  = 1'b1;
                        byte_d     = next_byte;
                        rs_d       = 1'b0;
                        stb_nibble = next_byte[7:4];
                        state_d    = NIB_HI;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        stb_nibble = init_nibble(idx_q + 2'd1);
                        state_d    = INIT_NIB;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    byte_d     = cmd_data;
                    rs_d       = cmd_rs;
                    stb_start  = 1'b1;
                    stb_nibble = cmd_data[7:4];
                    stb_rs     = cmd_rs;
                    state_d    = NIB_HI;
                end
            end
            NIB_HI: begin
                if (stb_done) begin
                    state_d = GAP;
                    cnt_d   = CW'(T_NIB - 1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    stb_start  = 1'b1;
                    stb_nibble = byte_q[3:0];
                    stb_rs     = rs_q;
                    state_d    = NIB_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NIB_LO: begin
                if (stb_done) begin
                    state_d = POST_WAIT;
                    cnt_d   = is_clear_home(rs_q, byte_q) ? CW'(T_CLEAR - 1)
                                                          : CW'(T_SHORT - 1);
                end
            end
            POST_WAIT: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
                    if (in_init_q && (idx_q != 2'd3)) begin
                        next_byte  = init_byte(idx_q + 2'd1);
                        idx_d      = idx_q + 2'd1;
                        byte_d     = next_byte;
                        rs_d       = 1'b0;
                        stb_start  = 1'b1;
                        stb_nibble = next_byte[7:4];
                        state_d    = NIB_HI;
                    end else begin
                        if (in_init_q) begin
                            in_init_d   = 1'b0;
                            init_done_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    lcd_nibble_strobe #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (stb_start),
        .nibble (stb_nibble),
        .rs     (stb_rs),
        .lcd_e  (lcd_e),
        .lcd_rs (lcd_rs),
        .lcd_db (lcd_db),
        .done   (stb_done)
    );

    assign cmd_ready = (state_q == IDLE) && init_done_q;
    assign busy      = (state_q != IDLE) || !init_done_q;
    assign init_done = init_done_q;
    assign sf_e      = 1'b1;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed self-checking bench for lcd_sequencer with scaled timing; covers
// both builds (LCD_INIT_EN defined or not).
`timescale 1ns/1ps
module tb_lcd_sequencer;

    localparam int P_PWRON = 100;
    localparam int P_INIT1 = 40;
    localparam int P_INIT2 = 10;
    localparam int P_SHORT = 8;
    localparam int P_CLEAR = 30;
    localparam int P_NIB   = 3;
    localparam int P_SETUP = 2;
    localparam int P_PULSE = 4;
    localparam int P_HOLD  = 1;

    localparam logic [4:0] INIT_EXP [12] = '{5'h03, 5'h03, 5'h03, 5'h02,
                                             5'h02, 5'h08, 5'h00, 5'h06,
                                             5'h00, 5'h0C, 5'h00, 5'h01};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, init_done, busy, sf_e, lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_db;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;
    int rise_cyc = 0;
    logic       e_prev = 1'b0;
    logic [4:0] cap = 5'h00;
    logic [4:0] pulses [$];

    lcd_sequencer #(
        .T_PWRON (P_PWRON), .T_INIT1 (P_INIT1), .T_INIT2 (P_INIT2),
        .T_SHORT (P_SHORT), .T_CLEAR (P_CLEAR), .T_NIB   (P_NIB),
        .T_SETUP (P_SETUP), .T_PULSE (P_PULSE), .T_HOLD  (P_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .init_done (init_done),
        .busy      (busy),
        .sf_e      (sf_e),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // E-pulse monitor: logs {rs,db} at each rise, checks width and hold stability at the fall
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            e_prev = 1'b0;
        end else begin
            if (lcd_e === 1'b1 && e_prev === 1'b0) begin
                cap = {lcd_rs, lcd_db};
                pulses.push_back(cap);
                rise_cyc = cyc;
            end
            if (lcd_e === 1'b0 && e_prev === 1'b1) begin
                check_output("e_width", cyc - rise_cyc, P_PULSE);
                check_output("hold_stable", {lcd_rs, lcd_db}, cap);
            end
            e_prev = lcd_e;
        end
    end

    task automatic check_pulse(input string tag, input logic [4:0] exp);
        if (pulses.size() == 0) check_output({tag, "_count"}, pulses.size(), 1);
        else check_output(tag, pulses.pop_front(), exp);
    endtask

    task automatic wait_ready(input int acc, input int exp_gap, input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_gap"}, cyc - acc, exp_gap);
    endtask

    task automatic apply_write(input logic rs, input logic [7:0] data, input int exp_gap, input string tag);
        int n = 0;
        int acc;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;
        cmd_rs    = ~rs;
        cmd_data  = ~data;
        check_output({tag, "_ready_low"}, cmd_ready, 0);
        wait_ready(acc, exp_gap, tag);
    endtask

    task automatic release_and_init(input string tag);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
`ifdef LCD_INIT_EN
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'hAA;
        while (lcd_e !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_first_e_rise"}, cyc - base, P_PWRON + P_SETUP);
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check_output({tag, "_init_done_cycle"}, cyc - base, 316);
        check_output({tag, "_ready_after_init"}, cmd_ready, 1);
        for (int i = 0; i < 12; i++) check_pulse({tag, "_init_nibble"}, INIT_EXP[i]);
        repeat (5) @(negedge clk);
        check_output({tag, "_no_queued_write"}, pulses.size(), 0);
`else
        @(negedge clk);
        check_output({tag, "_ready_first_cycle"}, cmd_ready, 1);
        check_output({tag, "_init_done_first_cycle"}, init_done, 1);
        check_output({tag, "_busy_idle"}, busy, 0);
        repeat (20) @(negedge clk);
        check_output({tag, "_no_e_activity"}, pulses.size(), 0);
`endif
    endtask

    initial begin
        int n;
        int acc1;
        int acc2;
        $display("[TB] lcd_sequencer directed test start");
        #1 rst_n = 1'b0;
        #1;
        check_output("rst_sf_e", sf_e, 1);
        check_output("rst_lcd_e", lcd_e, 0);
        check_output("rst_lcd_rs", lcd_rs, 0);
        check_output("rst_lcd_rw", lcd_rw, 0);
        check_output("rst_lcd_db", lcd_db, 0);
        check_output("rst_cmd_ready", cmd_ready, 0);
        check_output("rst_init_done", init_done, 0);
        check_output("rst_busy", busy, 1);
        repeat (3) @(negedge clk);

        release_and_init("boot");

`ifndef LCD_INIT_EN
        apply_write(1'b0, 8'h28, 2 * 7 + P_NIB + P_SHORT, "w28");
        check_pulse("w28_hi", 5'h02);
        check_pulse("w28_lo", 5'h08);
        check_output("w28_extra", pulses.size(), 0);
`endif

        apply_write(1'b1, 8'h41, 25, "w41");
        check_pulse("w41_hi", 5'h14);
        check_pulse("w41_lo", 5'h11);
        check_output("w41_extra", pulses.size(), 0);
        check_output("w41_lcd_rw", lcd_rw, 0);
        check_output("w41_sf_e", sf_e, 1);

        apply_write(1'b0, 8'h01, 47, "w01");
        check_pulse("w01_hi", 5'h00);
        check_pulse("w01_lo", 5'h01);
        check_output("w01_extra", pulses.size(), 0);

        // Back-to-back: valid held high across both transfers
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h48;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        acc1     = cyc;
        cmd_data = 8'h49;
        check_output("b2b_ready_low1", cmd_ready, 0);
        wait_ready(acc1, 25, "b2b_first");
        @(negedge clk);
        acc2      = cyc;
        cmd_valid = 1'b0;
        check_output("b2b_accept_spacing", acc2 - acc1, 26);
        check_output("b2b_ready_low2", cmd_ready, 0);
        wait_ready(acc2, 25, "b2b_second");
        check_pulse("b2b_p0", 5'h14);
        check_pulse("b2b_p1", 5'h18);
        check_pulse("b2b_p2", 5'h14);
        check_pulse("b2b_p3", 5'h19);
        check_output("b2b_extra", pulses.size(), 0);

        // Reset asserted while E is high on a data byte
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h55;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("midrst_e_seen", lcd_e, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midrst_lcd_e", lcd_e, 0);
        check_output("midrst_init_done", init_done, 0);
        check_output("midrst_busy", busy, 1);
        check_output("midrst_cmd_ready", cmd_ready, 0);
        check_output("midrst_lcd_db", lcd_db, 0);
        repeat (3) @(negedge clk);
        pulses.delete();
        release_and_init("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
